// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock) with
// start/busy/done handshake, overflow flag and seven-segment decode per digit.
module bin_to_bcd_seq #(
    parameter int WIDTH    = 8,
    parameter int DIGITS   = 3,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [7*DIGITS-1:0]   seg,
    output logic                  ovf
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'h3F;
            4'd1:    seg7 = 7'h06;
            4'd2:    seg7 = 7'h5B;
            4'd3:    seg7 = 7'h4F;
            4'd4:    seg7 = 7'h66;
            4'd5:    seg7 = 7'h6D;
            4'd6:    seg7 = 7'h7D;
            4'd7:    seg7 = 7'h07;
            4'd8:    seg7 = 7'h7F;
            4'd9:    seg7 = 7'h6F;
            default: seg7 = 7'h00;
        endcase
    endfunction

    // Display pattern for a value of zero, honouring blanking.
    function automatic logic [7*DIGITS-1:0] seg_zero();
        logic [7*DIGITS-1:0] r;
        for (int i = 0; i < DIGITS; i++)
            r[7*i +: 7] = (i == 0 || !BLANK_LZ) ? 7'h3F : 7'h00;
        return r;
    endfunction

    localparam logic [7*DIGITS-1:0] SEG_RST = seg_zero();

    state_t              state_q, state_d;
    logic [WIDTH-1:0]    sr_q, sr_d;
    logic [4*DIGITS-1:0] scr_q, scr_d, adj;
    logic                sticky_q, sticky_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [4*DIGITS-1:0] bcd_q, bcd_d;
    logic [7*DIGITS-1:0] seg_q, seg_d, seg_dec;
    logic                ovf_q, ovf_d;
    logic                done_q, done_d;

    always_comb begin
        adj = scr_q;
        for (int i = 0; i < DIGITS; i++)
            if (scr_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
    end

    // Walk from the top digit down; a digit is blanked until the first nonzero one.
    always_comb begin
        logic nz;
        nz      = 1'b0;
        seg_dec = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            nz = nz | (scr_q[4*i +: 4] != 4'd0);
            seg_dec[7*i +: 7] = (BLANK_LZ && i != 0 && !nz) ? 7'h00 : seg7(scr_q[4*i +: 4]);
        end
    end

    always_comb begin
        state_d  = state_q;
        sr_d     = sr_q;
        scr_d    = scr_q;
        sticky_d = sticky_q;
        cnt_d    = cnt_q;
        bcd_d    = bcd_q;
        seg_d    = seg_q;
        ovf_d    = ovf_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    sr_d     = bin;
                    scr_d    = '0;
                    sticky_d = 1'b0;
                    cnt_d    = CW'(WIDTH);
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                scr_d    = {adj[4*DIGITS-2:0], sr_q[WIDTH-1]};
                sr_d     = sr_q << 1;
                sticky_d = sticky_q | adj[4*DIGITS-1];
                cnt_d    = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) state_d = DONE;
            end
            DONE: begin
                bcd_d   = scr_q;
                ovf_d   = sticky_q;
                seg_d   = seg_dec;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            sr_q     <= '0;
            scr_q    <= '0;
            sticky_q <= 1'b0;
            cnt_q    <= '0;
            bcd_q    <= '0;
            seg_q    <= SEG_RST;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sr_q     <= sr_d;
            scr_q    <= scr_d;
            sticky_q <= sticky_d;
            cnt_q    <= cnt_d;
            bcd_q    <= bcd_d;
            seg_q    <= seg_d;
            ovf_q    <= ovf_d;
            done_q   <= done_d;
        end
    end

    assign busy = (state_q == SHIFT);
    assign done = done_q;
    assign bcd  = bcd_q;
    assign seg  = seg_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Scoreboard bench for bin_to_bcd_seq: four instances with different WIDTH/DIGITS/BLANK_LZ,
// expected results from a divide/modulo reference model, checked on done with latency.
module tb_bin_to_bcd_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic startA = 0, startB = 0, startC = 0, startD = 0;
    logic [7:0]  binA = 0, binB = 0, binC = 0;
    logic [15:0] binD = 0;
    logic busyA, busyB, busyC, busyD, doneA, doneB, doneC, doneD;
    logic ovfA, ovfB, ovfC, ovfD;
    logic [11:0] bcdA, bcdB;
    logic [7:0]  bcdC;
    logic [19:0] bcdD;
    logic [20:0] segA, segB;
    logic [13:0] segC;
    logic [34:0] segD;

    bin_to_bcd_seq #(.WIDTH(8),  .DIGITS(3), .BLANK_LZ(1'b1)) u_a (.clk(clk), .rst(rst), .start(startA),
        .bin(binA), .busy(busyA), .done(doneA), .bcd(bcdA), .seg(segA), .ovf(ovfA));
    bin_to_bcd_seq #(.WIDTH(8),  .DIGITS(3), .BLANK_LZ(1'b0)) u_b (.clk(clk), .rst(rst), .start(startB),
        .bin(binB), .busy(busyB), .done(doneB), .bcd(bcdB), .seg(segB), .ovf(ovfB));
    bin_to_bcd_seq #(.WIDTH(8),  .DIGITS(2), .BLANK_LZ(1'b1)) u_c (.clk(clk), .rst(rst), .start(startC),
        .bin(binC), .busy(busyC), .done(doneC), .bcd(bcdC), .seg(segC), .ovf(ovfC));
    bin_to_bcd_seq #(.WIDTH(16), .DIGITS(5), .BLANK_LZ(1'b1)) u_d (.clk(clk), .rst(rst), .start(startD),
        .bin(binD), .busy(busyD), .done(doneD), .bcd(bcdD), .seg(segD), .ovf(ovfD));

    int wd[4] = '{8, 8, 8, 16};
    int nd[4] = '{3, 3, 2, 5};
    int bl[4] = '{1, 0, 1, 1};

    typedef struct { logic [63:0] v; int t; } exp_t;
    exp_t q0[$], q1[$], q2[$], q3[$];
    exp_t me;
    int   ndone[4] = '{0, 0, 0, 0};
    int   n_chk = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] seg_ref(input int d);
        case (d)
            0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
            4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
            8: return 7'h7F;  9: return 7'h6F;  default: return 7'h00;
        endcase
    endfunction

    // Packed result: [55]=ovf, [54:20]=seg (7 bits/digit), [19:0]=bcd (4 bits/digit).
    function automatic logic [63:0] ref_model(input int val, input int ndig, input int blank);
        logic [63:0] r = '0;
        int p = 1, m, top = 0;
        int d[5];
        for (int i = 0; i < ndig; i++) p *= 10;
        m = val % p;
        for (int i = 0; i < ndig; i++) begin
            d[i] = m % 10;
            m    = m / 10;
            if (d[i] != 0) top = i;
        end
        for (int i = 0; i < ndig; i++) begin
            r[4*i +: 4]      = 4'(d[i]);
            r[20 + 7*i +: 7] = (blank != 0 && i > top) ? 7'h00 : seg_ref(d[i]);
        end
        r[55] = (val >= p);
        return r;
    endfunction

    function automatic logic [63:0] obs(input int id);
        case (id)
            0:       return 64'({ovfA, 35'(segA), 20'(bcdA)});
            1:       return 64'({ovfB, 35'(segB), 20'(bcdB)});
            2:       return 64'({ovfC, 35'(segC), 20'(bcdC)});
            default: return 64'({ovfD, 35'(segD), 20'(bcdD)});
        endcase
    endfunction

    function automatic logic gbusy(input int id);
        case (id) 0: return busyA; 1: return busyB; 2: return busyC; default: return busyD; endcase
    endfunction

    function automatic logic gdone(input int id);
        case (id) 0: return doneA; 1: return doneB; 2: return doneC; default: return doneD; endcase
    endfunction

    function automatic int qsize(input int id);
        case (id) 0: return q0.size(); 1: return q1.size(); 2: return q2.size(); default: return q3.size(); endcase
    endfunction

    task automatic push(input int id, input exp_t e);
        case (id) 0: q0.push_back(e); 1: q1.push_back(e); 2: q2.push_back(e); default: q3.push_back(e); endcase
    endtask

    task automatic pop(input int id, output exp_t e);
        case (id) 0: e = q0.pop_front(); 1: e = q1.pop_front(); 2: e = q2.pop_front(); default: e = q3.pop_front(); endcase
    endtask

    task automatic drive(input int id, input logic s, input int v);
        case (id)
            0:       begin startA = s; binA = 8'(v);  end
            1:       begin startB = s; binB = 8'(v);  end
            2:       begin startC = s; binC = 8'(v);  end
            default: begin startD = s; binD = 16'(v); end
        endcase
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            for (int id = 0; id < 4; id++) begin
                if (gdone(id)) begin
                    ndone[id]++;
                    if (qsize(id) == 0) chk($sformatf("spurious_done%0d", id), 1, 0);
                    else begin
                        pop(id, me);
                        chk($sformatf("res%0d", id), obs(id), me.v);
                        chk($sformatf("lat%0d", id), 64'(cyc), 64'(me.t));
                    end
                end
            end
        end
    end

    // Called just after a negedge with the instance idle; start is accepted on the next edge.
    task automatic conv(input int id, input int v);
        int acc = cyc + 1;
        int nd0 = ndone[id];
        int w   = wd[id];
        logic [63:0] ev = ref_model(v, nd[id], bl[id]);
        drive(id, 1'b1, v);
        push(id, '{ev, acc + w + 1});
        @(negedge clk);
        drive(id, 1'b0, int'($urandom));
        for (int r = 1; r <= w + 2; r++) begin
            @(negedge clk);
            if (r < w)      chk($sformatf("busy%0d", id), 64'(gbusy(id)), 1);
            if (r == w + 1) chk($sformatf("busy_done%0d", id), 64'(gbusy(id)), 0);
            if (r == w + 2) begin
                chk($sformatf("done_width%0d", id), 64'(gdone(id)), 0);
                chk($sformatf("hold%0d", id), obs(id), ev);
            end
        end
        chk($sformatf("done_cnt%0d", id), 64'(ndone[id] - nd0), 1);
    endtask

    initial begin
        int k, nd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int id = 0; id < 4; id++) begin
            chk($sformatf("rst_out%0d", id), obs(id), ref_model(0, nd[id], bl[id]));
            chk($sformatf("rst_busy%0d", id), 64'(gbusy(id)), 0);
            chk($sformatf("rst_done%0d", id), 64'(gdone(id)), 0);
        end

        conv(0, 255);
        conv(0, 0);
        conv(0, 105);
        conv(1, 7);
        conv(2, 123);
        conv(2, 99);
        conv(2, 100);
        conv(2, 255);

        // Start held high: accepts only when idle, bin changes mid-conversion ignored.
        k   = cyc;
        nd0 = ndone[0];
        drive(0, 1'b1, 200);
        push(0, '{ref_model(200, 3, 1), k + 10});
        push(0, '{ref_model(45, 3, 1),  k + 20});
        push(0, '{ref_model(45, 3, 1),  k + 30});
        for (int r = 1; r <= 21; r++) begin
            @(negedge clk);
            if (r == 3) drive(0, 1'b1, 45);
            if (r == 10 || r == 20) chk("held_idle_busy", 64'(busyA), 0);
            if (r == 11 || r == 21) chk("held_accept_busy", 64'(busyA), 1);
        end
        drive(0, 1'b0, 99);
        repeat (10) @(negedge clk);
        chk("held_done_cnt", 64'(ndone[0] - nd0), 3);

        // Reset partway through a conversion aborts it with no done pulse.
        k   = cyc;
        nd0 = ndone[0];
        drive(0, 1'b1, 77);
        @(negedge clk);
        drive(0, 1'b0, 0);
        while (cyc < k + 4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", 64'(busyA), 0);
        chk("abort_done", 64'(doneA), 0);
        chk("abort_out", obs(0), ref_model(0, 3, 1));
        rst = 1'b0;
        conv(0, 77);
        chk("abort_done_cnt", 64'(ndone[0] - nd0), 1);

        conv(3, 65535);
        conv(3, 0);
        conv(3, 10000);
        for (int i = 0; i < 200; i++) conv(3, int'($urandom_range(0, 65535)));
        for (int i = 0; i < 8; i++) begin
            conv(0, int'($urandom_range(0, 255)));
            conv(1, int'($urandom_range(0, 255)));
            conv(2, int'($urandom_range(0, 255)));
        end

        chk("sb_empty", 64'(qsize(0) + qsize(1) + qsize(2) + qsize(3)), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
